seq_nbit_adder: RTL and testbench

- Multi-cycle, parametrised N-bit adder.
- Captures two N-bit operands and a carry-in on a start pulse, then adds W bits per clock from LSB to MSB, carrying between slices through a register.
- Asserts a one-cycle done strobe with registered sum and carry-out.
- Sits in the arithmetic datapath as an area-lean option alongside the combinational half/full/ripple adders, and reuses those cells internally.

---
 rtl/arith_pkg.sv | 15 +
 rtl/full_adder.sv | 19 +
 rtl/half_adder.sv | 12 +
 rtl/slice_adder.sv | 28 ++
 rtl/seq_nbit_adder.sv | 125 ++++++++++++
 tb/tb_seq_nbit_adder.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types and helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for x states: max(1, clog2(x)).
  function automatic int unsigned cnt_width(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder composed of two half adders.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/slice_adder.sv
// Combinational W-bit ripple-carry adder built from full adders.
module slice_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  assign co = carry[W];

endmodule

// File: rtl/seq_nbit_adder.sv
// Multi-cycle N-bit adder: adds W bits per clock, LSB slice first.
module seq_nbit_adder
  import arith_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CYCLES = N / W;
  localparam int unsigned CNT_W  = cnt_width(CYCLES);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_param
    $error("seq_nbit_adder: W must divide N and satisfy 1 <= W <= N");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [N-1:0]       op_a_q, op_a_d;
  logic [N-1:0]       op_b_q, op_b_d;
  logic [N-1:0]       sum_d;
  logic               cout_d;
  logic [W-1:0]       slice_x;
  logic [W-1:0]       slice_y;
  logic [W-1:0]       slice_s;
  logic               slice_co;
  logic               last_c;

  assign last_c = (cnt_q == CNT_W'(CYCLES - 1));

  // Select the operand slice addressed by the counter.
  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int unsigned i = 0; i < CYCLES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        slice_x = op_a_q[i*W +: W];
        slice_y = op_b_q[i*W +: W];
      end
    end
  end

  slice_adder #(.W(W)) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Next-state and datapath updates; start is honoured only from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum;
    cout_d  = cout;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < CYCLES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[i*W +: W] = slice_s;
          end
        end
        carry_d = slice_co;
        if (last_c) begin
          cout_d  = slice_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum     <= sum_d;
      cout    <= cout_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_seq_nbit_adder.sv
// Directed and random checks for seq_nbit_adder across several N/W choices.
module tb_seq_nbit_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // N=8, W=2 instance
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  // N=8, W=8 and N=8, W=1 instances share stimulus
  logic       start3;
  logic [7:0] a3, b3;
  logic       cin3;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [7:0] sum1;

  // N=16, W=4 instance
  logic        start16;
  logic [15:0] a16, b16;
  logic        cin16;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  seq_nbit_adder #(.N(8), .W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  seq_nbit_adder #(.N(8), .W(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  seq_nbit_adder #(.N(8), .W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  seq_nbit_adder #(.N(16), .W(4)) dut_16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int overlap  = 0;

  // Count done pulses of the N=8/W=2 instance and busy/done overlap on the 16-bit one.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy16 && done16) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int t8, t1;
    logic [15:0] ra, rb;
    logic        rc;
    bit          seen;

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    tick(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: FF + 01 -> 00 carry 1, four busy cycles then done
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_busy%0d", i), {31'd0, busy, done}, 32'd2);
      tick();
    end
    check("t1_done", {31'd0, busy, done}, 32'd1);
    check("t1_sum",  32'(sum),  32'h00);
    check("t1_cout", 32'(cout), 32'd1);
    tick();
    check("t1_done_1cyc", 32'(done), 32'd0);
    check("t1_sum_hold",  32'(sum),  32'h00);

    // 2: start and operand changes during RUN are ignored
    base = done_cnt;
    a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    tick();
    a = 8'h00; b = 8'h00; cin = 1'b0;
    tick(4);
    start = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_sum",  32'(sum),  32'h97);
    check("t2_cout", 32'(cout), 32'd0);
    tick(8);
    check("t2_one_pulse", 32'(done_cnt - base), 32'd1);
    check("t2_idle", 32'(busy), 32'd0);

    // 4: back-to-back start in the DONE cycle
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    check("t4_first_done", 32'(done), 32'd1);
    check("t4_first_sum",  32'(sum),  32'h46);
    tick();
    start = 1'b0;
    check("t4_rerun", {31'd0, busy, done}, 32'd2);
    tick(4);
    check("t4_second_done", 32'(done), 32'd1);
    check("t4_second_sum",  32'(sum),  32'h30);
    check("t4_second_cout", 32'(cout), 32'd0);
    tick(2);

    // 5: reset mid-run aborts with no done
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  32'(sum),  32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    base = done_cnt;
    tick(8);
    check("t5_no_done", 32'(done_cnt - base), 32'd0);

    // 3: W=8 finishes after one slice, W=1 after eight
    a3 = 8'h80; b3 = 8'h80; cin3 = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("t3_busy8", 32'(busy8), 32'd1);
    check("t3_busy1", 32'(busy1), 32'd1);
    t8 = -1; t1 = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (done8 && t8 < 0) begin
        t8 = t;
        check("t3_sum8",  32'(sum8),  32'h01);
        check("t3_cout8", 32'(cout8), 32'd1);
      end
      if (done1 && t1 < 0) begin
        t1 = t;
        check("t3_sum1",  32'(sum1),  32'h01);
        check("t3_cout1", 32'(cout1), 32'd1);
      end
    end
    check("t3_lat8", 32'(t8), 32'd1);
    check("t3_lat1", 32'(t1), 32'd8);

    // 6: random 16-bit transactions, W=4
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      a16 = ra; b16 = rb; cin16 = rc; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        tick();
        if (done16) begin
          seen = 1'b1;
          check($sformatf("t6_sum%0d", n), {15'd0, cout16, sum16},
                32'(ra) + 32'(rb) + 32'(rc));
        end
      end
      if (!seen) check($sformatf("t6_timeout%0d", n), 32'd0, 32'd1);
      tick();
      check($sformatf("t6_pulse%0d", n), 32'(done16), 32'd0);
    end
    check("t6_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
